// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: accepts one op over valid/ready, runs a req/ack bus
// transfer with byte-lane steering and load extension, and reports alignment/timeout errors.
module mem_lsu #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_wd,
    input  logic                flush,
    output logic                stall_o,
    output logic                resp_valid,
    output logic                resp_wreg,
    output logic [4:0]          resp_wd,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic              accept, timeout_hit, flushed, bad_op;
    logic              we_r, signed_r, msb;
    logic [1:0]        size_r;
    logic [OFF_W-1:0]  base_r;
    logic [NB-1:0]     sel_new;
    logic [DATA_W-1:0] wdata_new, shifted, load_data;
    int                n_bytes, off_i, base_i;

    assign req_ready   = (state == IDLE) & ~rst;
    assign accept      = req_valid & req_ready & ~flush;
    assign stall_o     = (state == BUSY) | accept;
    assign bus_req     = (state == BUSY);
    assign resp_valid  = (state == RESP) & ~flushed & ~flush;
    assign resp_wreg   = resp_valid & ~we_r & (resp_err == 2'b00);
    assign bus_we      = we_r;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // Lane base: big-endian puts offset 0 in the most significant lane.
    always_comb begin
        n_bytes   = 1 << req_size;
        off_i     = int'(req_addr[OFF_W-1:0]);
        base_i    = (BIG_ENDIAN != 0) ? (NB - n_bytes - off_i) : off_i;
        bad_op    = ((off_i & (n_bytes - 1)) != 0) || (req_size == 2'd3 && DATA_W == 32);
        sel_new   = NB'(((1 << n_bytes) - 1) << base_i);
        wdata_new = '0;
        for (int i = 0; i < NB; i++)
            wdata_new[i*8 +: 8] = req_wdata[(i & (n_bytes - 1))*8 +: 8];
    end

    always_comb begin
        shifted   = bus_rdata >> {base_r, 3'b000};
        load_data = '0;
        case (size_r)
            2'd0:    msb = shifted[7];
            2'd1:    msb = shifted[15];
            2'd2:    msb = shifted[31];
            default: msb = shifted[DATA_W-1];
        endcase
        for (int j = 0; j < DATA_W; j++)
            load_data[j] = (j < (8 << size_r)) ? shifted[j] : (signed_r & msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // An ack wins over a timeout landing in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = bad_op ? RESP : BUSY;
            BUSY: if (bus_ack || timeout_hit) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; flushed <= 1'b0; we_r <= 1'b0; signed_r <= 1'b0;
            size_r <= '0; base_r <= '0; bus_addr <= '0; bus_sel <= '0;
            bus_wdata <= '0; resp_wd <= '0; resp_rdata <= '0; resp_err <= '0;
        end else if (accept) begin
            cnt        <= '0;
            flushed    <= 1'b0;
            we_r       <= req_we;
            signed_r   <= req_signed;
            size_r     <= req_size;
            base_r     <= OFF_W'(base_i);
            bus_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_sel    <= sel_new;
            bus_wdata  <= wdata_new;
            resp_wd    <= req_wd;
            resp_rdata <= '0;
            resp_err   <= bad_op ? 2'b01 : 2'b00;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (flush) flushed <= 1'b1;
            if (bus_ack) begin
                if (!we_r) resp_rdata <= load_data;
            end else if (timeout_hit) begin
                resp_err <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a big- and a little-endian instance share stimulus and
// are compared every cycle against a transaction-level expectation plus literal pins.
module tb_mem_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0, rst;
    logic        req_valid, req_we, req_signed, flush, bus_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, bus_rdata;
    logic [4:0]  req_wd;

    logic        b_req_ready, b_stall, b_resp_valid, b_resp_wreg, b_bus_req, b_bus_we;
    logic [4:0]  b_resp_wd;
    logic [31:0] b_resp_rdata, b_bus_addr, b_bus_wdata;
    logic [1:0]  b_resp_err;
    logic [3:0]  b_bus_sel;
    logic        l_req_ready, l_stall, l_resp_valid, l_resp_wreg, l_bus_req, l_bus_we;
    logic [4:0]  l_resp_wd;
    logic [31:0] l_resp_rdata, l_bus_addr, l_bus_wdata;
    logic [1:0]  l_resp_err;
    logic [3:0]  l_bus_sel;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    bit          exp_req_ready, exp_stall, exp_bus_req, exp_resp_valid, exp_we, exp_wreg;
    logic [31:0] exp_addr, exp_wdata, exp_rdata_b, exp_rdata_l;
    logic [3:0]  exp_sel_b, exp_sel_l;
    logic [1:0]  exp_err;
    logic [4:0]  exp_wd;

    int          cap_bus_cycles, cap_stall_cycles, cap_resp_count, cap_resp_cycle;
    logic [3:0]  cap_b_sel, cap_l_sel;
    logic [31:0] cap_wdata, cap_b_rdata, cap_l_rdata;
    logic [1:0]  cap_err;
    logic        cap_wreg;

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wd(req_wd), .flush(flush),
        .stall_o(b_stall), .resp_valid(b_resp_valid), .resp_wreg(b_resp_wreg),
        .resp_wd(b_resp_wd), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
        .bus_sel(b_bus_sel), .bus_wdata(b_bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata));

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(TO)) dut_le (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l_req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wd(req_wd), .flush(flush),
        .stall_o(l_stall), .resp_valid(l_resp_valid), .resp_wreg(l_resp_wreg),
        .resp_wd(l_resp_wd), .resp_rdata(l_resp_rdata), .resp_err(l_resp_err),
        .bus_req(l_bus_req), .bus_we(l_bus_we), .bus_addr(l_bus_addr),
        .bus_sel(l_bus_sel), .bus_wdata(l_bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int lane_base(input bit be, input logic [31:0] addr, input int n);
        int off = int'(addr[1:0]);
        return be ? (4 - n - off) : off;
    endfunction

    function automatic logic [3:0] model_sel(input bit be, input logic [31:0] addr, input int n);
        logic [3:0] s = '0;
        int b = lane_base(be, addr, n);
        for (int j = 0; j < n; j++) s[b + j] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input int n);
        case (n)
            1:       return {4{w[7:0]}};
            2:       return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_rdata(input bit be, input logic [31:0] addr, input int n,
                                                input bit sgn, input logic [31:0] rd);
        longint v = 0;
        int b = lane_base(be, addr, n);
        for (int j = 0; j < n; j++) v = v | (longint'(rd[8*(b+j) +: 8]) << (8*j));
        if (sgn && (((v >> (8*n - 1)) & 1) != 0)) v = v | ~((longint'(1) << (8*n)) - 1);
        return v[31:0];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        cmp("b_req_ready", 32'(b_req_ready), 32'(exp_req_ready));
        cmp("l_req_ready", 32'(l_req_ready), 32'(exp_req_ready));
        cmp("b_stall", 32'(b_stall), 32'(exp_stall));
        cmp("l_stall", 32'(l_stall), 32'(exp_stall));
        cmp("b_bus_req", 32'(b_bus_req), 32'(exp_bus_req));
        cmp("l_bus_req", 32'(l_bus_req), 32'(exp_bus_req));
        cmp("b_resp_valid", 32'(b_resp_valid), 32'(exp_resp_valid));
        cmp("l_resp_valid", 32'(l_resp_valid), 32'(exp_resp_valid));
        if (exp_bus_req) begin
            cmp("b_bus_we", 32'(b_bus_we), 32'(exp_we));
            cmp("b_bus_addr", b_bus_addr, exp_addr);
            cmp("b_bus_sel", 32'(b_bus_sel), 32'(exp_sel_b));
            cmp("l_bus_sel", 32'(l_bus_sel), 32'(exp_sel_l));
            if (exp_we) begin
                cmp("b_bus_wdata", b_bus_wdata, exp_wdata);
                cmp("l_bus_wdata", l_bus_wdata, exp_wdata);
            end
        end
        if (exp_resp_valid) begin
            cmp("b_resp_err", 32'(b_resp_err), 32'(exp_err));
            cmp("l_resp_err", 32'(l_resp_err), 32'(exp_err));
            cmp("b_resp_wreg", 32'(b_resp_wreg), 32'(exp_wreg));
            cmp("b_resp_wd", 32'(b_resp_wd), 32'(exp_wd));
            cmp("b_resp_rdata", b_resp_rdata, exp_rdata_b);
            cmp("l_resp_rdata", l_resp_rdata, exp_rdata_l);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (chk_en) checkOutput();
    end

    task automatic setIdle();
        exp_req_ready = 1'b1; exp_stall = 1'b0; exp_bus_req = 1'b0; exp_resp_valid = 1'b0;
    endtask

    // One op from accept to the idle cycle after its response; ack_c/flush_c/rst_c
    // are BUSY-cycle indices (1 = first) and 0 means never.
    task automatic applyStimulus(input bit we, input logic [1:0] size, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] wd, input logic [31:0] rdata,
                                 input int ack_c, input int flush_c, input int rst_c);
        int  n = 1 << size;
        bit  bad = (size == 2'd3) || ((addr % n) != 0);
        bit  busy, flushed = 1'b0, timed = 1'b0;
        int  c = 1;
        cap_bus_cycles = 0; cap_stall_cycles = 0; cap_resp_count = 0; cap_resp_cycle = -1;
        cap_b_sel = '0; cap_l_sel = '0; cap_wdata = '0; cap_b_rdata = '0; cap_l_rdata = '0;
        cap_err = '0; cap_wreg = 1'b0;
        exp_we = we; exp_addr = addr & ~32'h3; exp_wd = wd;
        exp_wdata = model_wdata(wdata, n);
        exp_sel_b = bad ? 4'h0 : model_sel(1'b1, addr, n);
        exp_sel_l = bad ? 4'h0 : model_sel(1'b0, addr, n);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr;
        req_wdata = wdata; req_wd = wd; bus_rdata = rdata; bus_ack = 1'b0; flush = 1'b0;
        exp_req_ready = 1'b1; exp_stall = 1'b1; exp_bus_req = 1'b0; exp_resp_valid = 1'b0;
        #3;
        if (b_stall) cap_stall_cycles++;
        busy = !bad;
        while (busy) begin
            @(negedge clk);
            req_valid = 1'b0;
            bus_ack = (c == ack_c);
            flush = (c == flush_c);
            if (c == flush_c) flushed = 1'b1;
            if (c == rst_c) begin
                rst = 1'b1;
                exp_req_ready = 1'b0; exp_stall = 1'b0; exp_bus_req = 1'b0; exp_resp_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0; bus_ack = 1'b0; flush = 1'b0;
                setIdle();
                return;
            end
            exp_req_ready = 1'b0; exp_stall = 1'b1; exp_bus_req = 1'b1; exp_resp_valid = 1'b0;
            #3;
            if (b_bus_req) begin
                cap_bus_cycles++;
                cap_b_sel = b_bus_sel; cap_l_sel = l_bus_sel; cap_wdata = b_bus_wdata;
            end
            if (b_stall) cap_stall_cycles++;
            if (c == ack_c) busy = 1'b0;
            else if (c == TO) begin busy = 1'b0; timed = 1'b1; end
            c++;
        end

        @(negedge clk);
        req_valid = 1'b0; bus_ack = 1'b0; flush = 1'b0;
        exp_req_ready = 1'b0; exp_stall = 1'b0; exp_bus_req = 1'b0; exp_resp_valid = !flushed;
        exp_err  = bad ? 2'b01 : (timed ? 2'b10 : 2'b00);
        exp_wreg = !we && (exp_err == 2'b00);
        exp_rdata_b = exp_wreg ? model_rdata(1'b1, addr, n, sgn, rdata) : 32'h0;
        exp_rdata_l = exp_wreg ? model_rdata(1'b0, addr, n, sgn, rdata) : 32'h0;
        #3;
        if (b_resp_valid) begin
            cap_resp_count++; cap_resp_cycle = c;
            cap_b_rdata = b_resp_rdata; cap_l_rdata = l_resp_rdata;
            cap_err = b_resp_err; cap_wreg = b_resp_wreg;
        end
        if (b_stall) cap_stall_cycles++;

        @(negedge clk);
        setIdle();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_wd = '0; flush = 1'b0; bus_ack = 1'b0;
        bus_rdata = '0;
        exp_req_ready = 1'b0; exp_stall = 1'b0; exp_bus_req = 1'b0; exp_resp_valid = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        setIdle();

        // LB signed, immediate ack
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 5'd3, 32'h12803456, 1, 0, 0);
        cmp("lb_sel_be", 32'(cap_b_sel), 32'h4);
        cmp("lb_rdata_be", cap_b_rdata, 32'hFFFFFF80);
        cmp("lb_rdata_le", cap_l_rdata, 32'h00000034);
        cmp("lb_wreg", 32'(cap_wreg), 32'h1);
        cmp("lb_resp_cycle", 32'(cap_resp_cycle), 32'd2);

        // SH
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h0002, 32'h0000ABCD, 5'd7, 32'h0, 2, 0, 0);
        cmp("sh_sel_be", 32'(cap_b_sel), 32'h3);
        cmp("sh_sel_le", 32'(cap_l_sel), 32'hC);
        cmp("sh_wdata", cap_wdata, 32'hABCDABCD);
        cmp("sh_wreg", 32'(cap_wreg), 32'h0);
        cmp("sh_err", 32'(cap_err), 32'h0);

        // misaligned LW and illegal LD
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0006, 32'h0, 5'd4, 32'hFFFFFFFF, 1, 0, 0);
        cmp("lw_mis_busreq", 32'(cap_bus_cycles), 32'd0);
        cmp("lw_mis_err", 32'(cap_err), 32'h1);
        cmp("lw_mis_resp_cycle", 32'(cap_resp_cycle), 32'd1);
        cmp("lw_mis_wreg", 32'(cap_wreg), 32'h0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0008, 32'h0, 5'd5, 32'hFFFFFFFF, 1, 0, 0);
        cmp("ld_err", 32'(cap_err), 32'h1);
        cmp("ld_busreq", 32'(cap_bus_cycles), 32'd0);

        // ack in 3rd BUSY cycle
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0010, 32'h0, 5'd9, 32'hDEADBEEF, 3, 0, 0);
        cmp("lw_stall_cycles", 32'(cap_stall_cycles), 32'd4);
        cmp("lw_resp_cycle", 32'(cap_resp_cycle), 32'd4);
        cmp("lw_rdata", cap_b_rdata, 32'hDEADBEEF);

        // timeout, then a following op
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0020, 32'h0, 5'd1, 32'h11223344, 0, 0, 0);
        cmp("to_busreq_cycles", 32'(cap_bus_cycles), 32'd8);
        cmp("to_err", 32'(cap_err), 32'h2);
        cmp("to_resp_cycle", 32'(cap_resp_cycle), 32'd9);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h0022, 32'h0, 5'd2, 32'h80017FFE, 1, 0, 0);
        cmp("lh_rdata_be", cap_b_rdata, 32'h00007FFE);
        cmp("lh_rdata_le", cap_l_rdata, 32'hFFFF8001);

        // flush in BUSY
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0030, 32'h0, 5'd6, 32'hCAFEF00D, 4, 2, 0);
        cmp("flush_resp_count", 32'(cap_resp_count), 32'd0);
        cmp("flush_busreq_cycles", 32'(cap_bus_cycles), 32'd4);

        // flush with req_valid in IDLE; stray ack ignored
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; bus_ack = 1'b1; req_addr = 32'h40; req_size = 2'd2;
        setIdle();
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
        setIdle();

        // reset mid-BUSY
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0050, 32'h0, 5'd8, 32'h0, 0, 0, 2);
        cmp("rst_busreq_cycles", 32'(cap_bus_cycles), 32'd1);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h0063, 32'h000000A5, 5'd0, 32'h0, 1, 0, 0);
        cmp("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        cmp("sb_sel_be", 32'(cap_b_sel), 32'h1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Parametrised load/store unit for the MEM stage; the successor to the purely combinational access path. It accepts one memory op per transaction from EX/MEM over a valid/ready handshake. It drives a variable-latency data bus with a req/ack handshake and stalls the pipeline until completion. It steers byte lanes for either endianness, sign- or zero-extends load data, and reports misalignment and bus-timeout errors to the CP0 exception logic.

Parameters:
DATA_W, 32, bus data width; 32 or 64
ADDR_W, 32, address width
BIG_ENDIAN, 1, 1: byte offset 0 maps to the MS lane; 0: byte offset 0 maps to the LS lane
TIMEOUT, 16, bus_req cycles without bus_ack before a bus error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  op present from EX/MEM
req_ready  out  1  unit can accept an op
req_we  in  1  1 store, 0 load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword
req_signed  in  1  sign-extend the load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
req_wd  in  5  load destination register
flush  in  1  kill the current op's response
stall_o  out  1  stall request to pipeline control
resp_valid  out  1  one-cycle result pulse
resp_wreg  out  1  write the register file
resp_wd  out  5  destination register
resp_rdata  out  DATA_W  extended load data
resp_err  out  2  00 ok, 01 misaligned/illegal size, 10 bus timeout
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  ADDR_W  bus address, lane bits cleared
bus_sel  out  DATA_W/8  byte enables
bus_wdata  out  DATA_W  store data
bus_ack  in  1  transfer complete
bus_rdata  in  DATA_W  read data, valid when bus_ack is high

Behaviour:
- Reset: state IDLE, timeout counter 0. All registered outputs are 0. req_ready is forced to 0 while rst is high. Reset mid-transaction drops bus_req immediately and produces no response.
- States and transitions:
  - IDLE: req_ready=1. Accept on req_valid & req_ready & ~flush. A legal op goes to BUSY; a misaligned or illegal op goes to RESP with err=01.
  - BUSY: bus_req=1, with bus_addr, sel, we and wdata held stable.
    - On bus_req & bus_ack, go to RESP, registering the extracted load data.
    - If no ack arrives after TIMEOUT cycles, drop bus_req and go to RESP with err=10.
  - RESP: resp_valid=1 for one cycle, then return to IDLE. A new op is not accepted in RESP.
- Misalignment: err=01 when addr mod 2^size != 0. err=01 also when size=3 with DATA_W=32. No bus_req is issued in either case.
- Lane selection, with NB = DATA_W/8, off = addr mod NB, n = 2^size:
  - Lane base is (NB-n-off) when BIG_ENDIAN=1, otherwise off.
  - bus_sel = (2^n - 1) << base.
  - Load bytes are taken from bus_rdata lanes [base+n-1:base].
  - The load result is zero- or sign-extended per req_signed from the field's MS bit.
- Store data: the low n bytes of req_wdata are replicated across all lanes.
- Response fields:
  - resp_wreg = ~we & (err==00).
  - resp_wd carries req_wd.
  - resp_rdata is 0 for stores and errors.
- Latency: accept at edge N, bus_req high from cycle N+1. An ack in cycle N+k gives resp_valid in cycle N+k+1.
- stall_o = (state==BUSY) | (state==IDLE & accept). stall_o is low in RESP.
- Flush:
  - Flush in BUSY does not abort the bus transaction; it completes per protocol.
  - A flush seen in BUSY or RESP suppresses resp_valid, which stays 0.
  - flush together with req_valid in IDLE: the op is not accepted.
- Timeout counter: clears on accept and increments each BUSY cycle.
- An ack in the same cycle the counter reaches TIMEOUT counts as success.
- bus_ack outside BUSY is ignored.

Test Plan:
- LB signed, DATA_W=32, BIG_ENDIAN=1, addr 0x1001, bus_rdata 0x12803456, immediate ack -> bus_sel 0100, resp_rdata 0xFFFFFF80, resp_wreg 1, resp_valid in cycle N+2.
- SH, addr 0x0002, wdata 0x0000ABCD -> bus_we 1, bus_sel 0011, bus_wdata 0xABCDABCD, resp_wreg 0, err 00. BIG_ENDIAN=0 gives bus_sel 1100.
- LW at addr 0x0006, and LD with DATA_W=32 -> no bus_req, resp_valid the next cycle with err 01, resp_wreg 0.
- Ack delayed until the 3rd BUSY cycle -> stall_o high for 4 cycles, bus signals stable throughout, resp_valid exactly one cycle after ack.
- TIMEOUT=8 with bus_ack held low -> bus_req high for exactly 8 cycles then low, resp_err 10. A second op is accepted after RESP.
- Flush in the 2nd BUSY cycle with ack in the 4th -> bus completes normally, resp_valid never asserts, req_ready 1 afterwards. Separately, rst in BUSY -> bus_req 0 in the same cycle.
